// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and small decode helpers used by the ALU front end.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } state_e;

    // Operations that occupy the iterative datapath (raise oBusy).
    function automatic logic op_is_iter(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operands are reduced to magnitudes at accept, processed one bit per cycle,
// and the sign is restored in a final fix-up cycle.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for iStart; MTHI/MTLO complete here in one edge
//   CALC    | WIDTH iterations of shift-add multiply or restoring divide
//   SIGN    | sign fix-up, HI/LO write, oDone pulse (also divide-by-zero)
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             iStart,
    input  logic [2:0]       iOp,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic             oDivByZero,
    output logic [WIDTH-1:0] oHI,
    output logic [WIDTH-1:0] oLO
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

    state_e               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH:0]     work;
    logic [WIDTH-1:0]     b_mag;
    logic                 is_div, neg_res, neg_rem, dbz;

    logic                 accept, acc_iter, div_zero, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag_in;
    logic [WIDTH:0]       mul_sum, rem_try, div_diff;
    logic                 div_ge;
    logic [2*WIDTH:0]     mul_nxt, div_nxt;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign oBusy    = (state != ST_IDLE);
    assign accept   = iStart && (state == ST_IDLE);
    assign acc_iter = accept && op_is_iter(iOp);
    assign div_zero = op_is_div(iOp) && (iB == '0);

    // |MIN| intentionally wraps to MIN, which is the correct unsigned magnitude.
    assign a_neg    = op_is_signed(iOp) && iA[WIDTH-1];
    assign b_neg    = op_is_signed(iOp) && iB[WIDTH-1];
    assign a_mag    = a_neg ? -iA : iA;
    assign b_mag_in = b_neg ? -iB : iB;

    // Multiply step: conditionally add multiplicand into upper half, shift right.
    assign mul_sum  = work[2*WIDTH:WIDTH] + (work[0] ? {1'b0, b_mag} : '0);
    assign mul_nxt  = {1'b0, mul_sum, work[WIDTH-1:1]};

    // Divide step: shift left, trial-subtract divisor, quotient bit enters at LSB.
    assign rem_try  = work[2*WIDTH-1:WIDTH-1];
    assign div_ge   = (rem_try >= {1'b0, b_mag});
    assign div_diff = rem_try - {1'b0, b_mag};
    assign div_nxt  = {(div_ge ? div_diff : rem_try), work[WIDTH-2:0], div_ge};

    assign prod_fix = neg_res ? -work[2*WIDTH-1:0]     : work[2*WIDTH-1:0];
    assign quo_fix  = neg_res ? -work[WIDTH-1:0]       : work[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];

    // State register.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode; a zero divisor bypasses CALC entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (acc_iter) state_nxt = div_zero ? ST_SIGN : ST_CALC;
            ST_CALC: if (cnt == CW'(1)) state_nxt = ST_SIGN;
            ST_SIGN: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and HI/LO write-back.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            cnt        <= '0;
            work       <= '0;
            b_mag      <= '0;
            is_div     <= 1'b0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            dbz        <= 1'b0;
            oHI        <= '0;
            oLO        <= '0;
            oDone      <= 1'b0;
            oDivByZero <= 1'b0;
        end else begin
            oDone      <= 1'b0;
            oDivByZero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && (iOp == OP_MTHI)) oHI <= iA;
                    if (accept && (iOp == OP_MTLO)) oLO <= iA;
                    if (acc_iter) begin
                        is_div  <= op_is_div(iOp);
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        dbz     <= div_zero;
                        b_mag   <= b_mag_in;
                        // On divide-by-zero the raw dividend is parked for HI.
                        work    <= {{(WIDTH+1){1'b0}}, (div_zero ? iA : a_mag)};
                        cnt     <= div_zero ? '0 : CNT_LOAD;
                    end
                end
                ST_CALC: begin
                    work <= is_div ? div_nxt : mul_nxt;
                    cnt  <= cnt - CW'(1);
                end
                ST_SIGN: begin
                    oDone      <= 1'b1;
                    oDivByZero <= dbz;
                    if (dbz) begin
                        oHI <= work[WIDTH-1:0];
                        oLO <= '1;
                    end else if (is_div) begin
                        oHI <= rem_fix;
                        oLO <= quo_fix;
                    end else begin
                        oHI <= prod_fix[2*WIDTH-1:WIDTH];
                        oLO <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): a driver issues operations and
// queues expected HI/LO from an arithmetic reference model; a monitor pops and
// compares on every oDone and checks HI/LO stability in between.
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic        iCLK, iRST_n, iStart;
    logic [2:0]  iOp;
    logic [31:0] iA, iB;
    logic        oBusy, oDone, oDivByZero;
    logic [31:0] oHI, oLO;

    exp_t        exp_q[$];
    logic [31:0] arch_hi, arch_lo;
    bit          mon_en;
    int          n_cmp, n_mis;

    muldiv_unit #(.WIDTH(32)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iStart(iStart), .iOp(iOp),
        .iA(iA), .iB(iB), .oBusy(oBusy), .oDone(oDone),
        .oDivByZero(oDivByZero), .oHI(oHI), .oLO(oLO)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain 64-bit arithmetic; SV / and % truncate toward zero.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.dbz = 1'b0;
        e.hi  = '0;
        e.lo  = '0;
        case (op)
            3'd0: begin p = 64'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    e.dbz = 1'b1; e.hi = a; e.lo = 32'hFFFF_FFFF;
                end else if (op == 3'd2) begin
                    q = sa / sb; r = sa % sb;
                    e.hi = r[31:0]; e.lo = q[31:0];
                end else begin
                    e.hi = a % b; e.lo = a / b;
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request; optionally inject an MTHI at E5 or a reset after E<rst_at>.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit inject_mthi, input int rst_at);
        int n, lat_exp;
        iStart = 1'b1; iOp = op; iA = a; iB = b;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        if (op == 3'd4) arch_hi = a;
        if (op == 3'd5) arch_lo = a;
        if (op > 3'd3) begin
            chk("no_busy_single_cycle_op", {63'd0, oBusy}, 64'd0);
            return;
        end
        exp_q.push_back(model(op, a, b));
        chk("busy_after_accept", {63'd0, oBusy}, 64'd1);
        lat_exp = (op >= 3'd2 && b == 32'd0) ? 1 : 33;
        n = 0;
        while (oBusy && n < 100) begin
            if (rst_at != 0 && n == rst_at) begin
                exp_q.delete();
                arch_hi = '0; arch_lo = '0;
                iRST_n = 1'b0;
                #1;
                chk("rst_abort_hi", oHI, 0);
                chk("rst_abort_lo", oLO, 0);
                chk("rst_abort_busy", {63'd0, oBusy}, 0);
                chk("rst_abort_done", {63'd0, oDone}, 0);
                iStart = 1'b0;
                repeat (3) @(posedge iCLK);
                #1 iRST_n = 1'b1;
                repeat (40) @(posedge iCLK);
                #1 chk("idle_after_rst", {63'd0, oBusy}, 0);
                return;
            end
            iA = $urandom; iB = $urandom; iOp = 3'($urandom_range(0, 7));
            iStart = ($urandom_range(0, 3) == 0);
            if (inject_mthi && n == 4) begin
                iStart = 1'b1; iOp = 3'd4; iA = 32'h1234_5678;
            end
            @(posedge iCLK); #1;
            n++;
        end
        iStart = 1'b0;
        chk("busy_latency", 64'(n), 64'(lat_exp));
    endtask

    // Monitor: score completions, and require HI/LO to hold otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge iCLK);
            if (mon_en) begin
                chk("dbz_without_done", {63'd0, oDivByZero & ~oDone}, 0);
                if (oDone) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", {63'd0, oDone}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result_hi", oHI, e.hi);
                        chk("result_lo", oLO, e.lo);
                        chk("result_dbz", {63'd0, oDivByZero}, {63'd0, e.dbz});
                        arch_hi = e.hi;
                        arch_lo = e.lo;
                    end
                end else begin
                    chk("hold_hi", oHI, arch_hi);
                    chk("hold_lo", oLO, arch_lo);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        n_cmp = 0; n_mis = 0; mon_en = 1'b0;
        arch_hi = '0; arch_lo = '0;
        iRST_n = 1'b0; iStart = 1'b0; iOp = '0; iA = '0; iB = '0;
        #1;
        chk("reset_hi", oHI, 0);
        chk("reset_lo", oLO, 0);
        chk("reset_busy", {63'd0, oBusy}, 0);
        chk("reset_done", {63'd0, oDone}, 0);
        chk("reset_dbz", {63'd0, oDivByZero}, 0);
        repeat (2) @(posedge iCLK);
        #1 iRST_n = 1'b1;
        mon_en = 1'b1;
        @(posedge iCLK); #1;

        issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 0);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 0);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        issue(3'd3, 32'h0000_0007, 32'h0000_0000, 1'b0, 0);
        issue(3'd4, 32'hCAFE_0001, 32'h0, 1'b0, 0);
        issue(3'd5, 32'hBEEF_0002, 32'h0, 1'b0, 0);
        issue(3'd6, 32'hDEAD_0003, 32'h0, 1'b0, 0);
        issue(3'd7, 32'hDEAD_0004, 32'h0, 1'b0, 0);
        issue(3'd1, 32'h0000_0003, 32'h0000_0004, 1'b0, 0);
        issue(3'd1, 32'h1111_1111, 32'h2222_2222, 1'b0, 10);
        issue(3'd3, 32'h0000_0064, 32'h0000_0007, 1'b0, 0);

        for (int i = 0; i < 120; i++) begin
            issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), 1'b0, 0);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(posedge iCLK);
            #0;
        end

        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge iCLK); w++;
        end
        repeat (2) @(posedge iCLK);
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO width; SHALL be legal for any even value 4..64.
REQ-002 iCLK  in  1  single clock; all state SHALL update on rising edge.
REQ-003 iRST_n  in  1  reset, asynchronous, active-low.
REQ-004 iStart  in  1  request strobe, sampled on iCLK edge.
REQ-005 iOp  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved.
REQ-006 iA  in  WIDTH  multiplicand/dividend/MTHI-MTLO source.
REQ-007 iB  in  WIDTH  multiplier/divisor.
REQ-008 oBusy  out  1  iterative operation in progress.
REQ-009 oDone  out  1  one-cycle pulse: new HI/LO valid.
REQ-010 oDivByZero  out  1  one-cycle pulse, coincident with oDone, divisor was zero.
REQ-011 oHI, oLO  out  WIDTH  architectural HI/LO registers, registered outputs.

Function
REQ-012 States IDLE, CALC, SIGN; start accepted only in IDLE (iStart=1, oBusy=0).
REQ-013 iStart while oBusy=1, or with a reserved iOp, SHALL be ignored without state change.
REQ-014 MTHI/MTLO SHALL write iA into HI/LO at the accepting edge; no busy, no oDone.
REQ-015 MULT/DIV start SHALL latch iA, iB, iOp; later input changes SHALL have no effect.
REQ-016 Signed ops SHALL work on magnitudes (|MIN| = MIN as unsigned); sign fix-up done in SIGN.
REQ-017 CALC SHALL run exactly WIDTH cycles, one bit per cycle: shift-add multiply, restoring divide.
REQ-018 Accept at edge E0: oBusy=1 from E0 to E(WIDTH+1); at E(WIDTH+1) HI/LO written, oBusy=0, oDone=1 for one cycle.
REQ-019 MULT/MULTU: {HI,LO} = full 2*WIDTH-bit product, signed or unsigned.
REQ-020 DIV/DIVU: LO = quotient truncated toward zero, HI = remainder with sign of dividend.
REQ-021 DIV MIN / -1 SHALL yield LO=MIN, HI=0, no error flag.
REQ-022 Divisor zero: skip CALC; at E1 HI=iA, LO=all ones, oDone=1, oDivByZero=1, oBusy=0 after E1.
REQ-023 HI/LO SHALL hold previous values throughout oBusy; readable any cycle.
REQ-024 New start SHALL be accepted in the oDone cycle (back-to-back allowed).

Reset
REQ-025 iRST_n=0 SHALL immediately force IDLE, HI=0, LO=0, oBusy=0, oDone=0, oDivByZero=0, counter=0.
REQ-026 Reset during CALC/SIGN SHALL abort with no oDone and no HI/LO update; release SHALL resume in IDLE.

Structure
REQ-027 Shared package muldiv_pkg SHALL hold iOp encodings and state encoding; ALU decode SHALL import it.
REQ-028 Single module, no sub-module; one iteration counter of clog2(WIDTH+1) bits, one 2*WIDTH+1-bit working register.

Verification (WIDTH=32)
REQ-029 MULT iA=FFFFFFFD, iB=00000005 -> oDone at E33, HI=FFFFFFFF, LO=FFFFFFF1.
REQ-030 MULTU iA=iB=FFFFFFFF -> HI=FFFFFFFE, LO=00000001 at E33.
REQ-031 DIV iA=FFFFFFF9, iB=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF; then DIV 80000000/FFFFFFFF -> LO=80000000, HI=00000000.
REQ-032 DIVU iA=00000007, iB=0 -> at E1 oDone=oDivByZero=1, HI=00000007, LO=FFFFFFFF.
REQ-033 MULTU started, iStart+MTHI at E5 -> ignored, HI unchanged until E33; iRST_n low at E10 of second op -> HI=LO=0, no oDone, IDLE.
